// File: rtl/disp_scan4_if.sv
// rtl/disp_scan4_if.sv - digit inputs and 7-segment display outputs of disp_scan4
//
// Purpose: bundles the four 5-bit digit codes and the multiplexed display drive.
// Signals:
//   ones/tens/hund/thou [4:0] : [3:0] hex code, [4] decimal point
//   seg [6:0]                 : segments a..g, active-high
//   dp                        : decimal point, active-high
//   dig [3:0]                 : one-hot digit enable, dig[0]=ones
//   frame                     : one-cycle pulse when the snapshot loads
// Modports: master drives digits / observes display, slave is the scanner.
interface disp_scan4_if;
    logic [4:0] ones;
    logic [4:0] tens;
    logic [4:0] hund;
    logic [4:0] thou;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       frame;

    modport master (
        output ones, tens, hund, thou,
        input  seg, dp, dig, frame
    );

    modport slave (
        input  ones, tens, hund, thou,
        output seg, dp, dig, frame
    );
endinterface

// File: rtl/disp_scan4.sv
// rtl/disp_scan4.sv - four-digit multiplexed 7-segment scanner with snapshot and blanking
//
// Purpose: scans ones, tens, hund, thou onto a common-cathode display, one digit
// slot of PRESCALE clocks each, with BLANK_CYC clocks of dead time at the start
// of each slot and optional leading-zero blanking. The digit inputs are sampled
// once per frame so a changing count never tears the display.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   dsp : disp_scan4_if.slave (digit inputs, seg/dp/dig/frame outputs)
module disp_scan4 #(
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 4,
    parameter int LZB       = 1
) (
    input  logic       clk,
    input  logic       rst,
    disp_scan4_if.slave dsp
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [1:0]      idx_q, idx_nxt;
    logic [3:0][4:0] snap_q, snap_nxt;
    logic            load;
    logic            lit;
    logic [4:0]      sel;
    logic [3:0]      blank_vec;
    logic [6:0]      seg_nxt;
    logic [3:0]      dig_nxt;
    logic            dp_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0: seg_decode = 7'h3F;
            4'h1: seg_decode = 7'h06;
            4'h2: seg_decode = 7'h5B;
            4'h3: seg_decode = 7'h4F;
            4'h4: seg_decode = 7'h66;
            4'h5: seg_decode = 7'h6D;
            4'h6: seg_decode = 7'h7D;
            4'h7: seg_decode = 7'h07;
            4'h8: seg_decode = 7'h7F;
            4'h9: seg_decode = 7'h6F;
            4'hA: seg_decode = 7'h77;
            4'hB: seg_decode = 7'h7C;
            4'hC: seg_decode = 7'h39;
            4'hD: seg_decode = 7'h5E;
            4'hE: seg_decode = 7'h79;
            default: seg_decode = 7'h71;
        endcase
    endfunction

    // Dead-time gate; a zero-length dead time is handled separately so the
    // comparison never degenerates into an always-true unsigned compare.
    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign lit = 1'b1;
        end else begin : g_dead
            assign lit = (cnt_nxt >= CW'(BLANK_CYC));
        end
    endgenerate

    always_comb begin
        load      = 1'b0;
        cnt_nxt   = cnt_q + CW'(1);
        idx_nxt   = idx_q;
        snap_nxt  = snap_q;
        blank_vec = 4'b0000;
        sel       = 5'd0;
        seg_nxt   = 7'h00;
        dig_nxt   = 4'b0000;
        dp_nxt    = 1'b0;

        if (cnt_q == CNT_MAX) begin
            cnt_nxt = '0;
            idx_nxt = idx_q + 2'd1;
            load    = (idx_q == 2'd3);
        end

        if (load) begin
            snap_nxt = {dsp.thou, dsp.hund, dsp.tens, dsp.ones};
        end

        // A digit is a leading zero when it and every more-significant digit
        // are zero; the ones digit always shows.
        if (LZB != 0) begin
            blank_vec[3] = (snap_nxt[3][3:0] == 4'h0);
            blank_vec[2] = blank_vec[3] && (snap_nxt[2][3:0] == 4'h0);
            blank_vec[1] = blank_vec[2] && (snap_nxt[1][3:0] == 4'h0);
        end

        // Outputs come from next-state values so they line up with cnt/idx.
        sel = snap_nxt[idx_nxt];
        if (lit) begin
            dig_nxt = 4'b0001 << idx_nxt;
            dp_nxt  = sel[4];
            seg_nxt = blank_vec[idx_nxt] ? 7'h00 : seg_decode(sel[3:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= CNT_MAX;
            idx_q     <= 2'd3;
            snap_q    <= '0;
            dsp.seg   <= 7'h00;
            dsp.dp    <= 1'b0;
            dsp.dig   <= 4'b0000;
            dsp.frame <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            idx_q     <= idx_nxt;
            snap_q    <= snap_nxt;
            dsp.seg   <= seg_nxt;
            dsp.dp    <= dp_nxt;
            dsp.dig   <= dig_nxt;
            dsp.frame <= load;
        end
    end
endmodule

// File: tb/tb_disp_scan4.sv
// tb/tb_disp_scan4.sv - self-checking bench for disp_scan4 (two parameter sets)
module tb_disp_scan4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    disp_scan4_if ifa ();
    disp_scan4_if ifb ();

    disp_scan4 #(.PRESCALE(4), .BLANK_CYC(1), .LZB(1)) dut_a (
        .clk(clk), .rst(rst), .dsp(ifa.slave)
    );
    disp_scan4 #(.PRESCALE(4), .BLANK_CYC(0), .LZB(0)) dut_b (
        .clk(clk), .rst(rst), .dsp(ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: k = clock edges since reset release, snap = frame copy.
    int         k;
    logic [4:0] cur  [4];
    logic [4:0] snap [4];
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void expect_out(input int bl, input bit lzb,
                                       output logic [6:0] seg, output logic [3:0] dig,
                                       output logic dp, output logic frame);
        int p, slot, off;
        bit blank;
        seg = 7'h00; dig = 4'b0000; dp = 1'b0; frame = 1'b0;
        if (k == 0) return;
        p     = (k - 1) % 16;
        slot  = p / 4;
        off   = p % 4;
        frame = (p == 0);
        if (off < bl) return;
        dig   = 4'(1 << slot);
        dp    = snap[slot][4];
        blank = 1'b0;
        if (lzb && slot > 0) begin
            blank = 1'b1;
            for (int j = slot; j < 4; j++)
                if (snap[j][3:0] != 4'h0) blank = 1'b0;
        end
        seg = blank ? 7'h00 : seg_tab[snap[slot][3:0]];
    endfunction

    task automatic set_in(input logic [4:0] o, input logic [4:0] t,
                          input logic [4:0] h, input logic [4:0] th);
        cur[0] = o; cur[1] = t; cur[2] = h; cur[3] = th;
        ifa.ones = o; ifa.tens = t; ifa.hund = h; ifa.thou = th;
        ifb.ones = o; ifb.tens = t; ifb.hund = h; ifb.thou = th;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            k++;
            if ((k - 1) % 16 == 0)
                for (int i = 0; i < 4; i++) snap[i] = cur[i];
        end
        #1;
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 4; i++) snap[i] = 5'd0;
    endtask

    task automatic sync_frame();
        for (int i = 0; i < 16 && (k % 16) != 0; i++) tick();
    endtask

    task automatic test_reset();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        rst = 1'b0;
        model_reset();
        set_in(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        tick(); tick();
        checks++;
        if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== 13'd0 ||
            {ifb.seg, ifb.dp, ifb.dig, ifb.frame} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold got a=%h b=%h required 0", {ifa.seg, ifa.dp, ifa.dig, ifa.frame},
                     {ifb.seg, ifb.dp, ifb.dig, ifb.frame});
        end
        set_in(5'd4, 5'd3, 5'd2, 5'd1);
        rst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            expect_out(1, 1'b1, es, ed, ep, ef);
            checks++;
            if (ifa.frame !== (c == 1) || ifa.dig !== ((c == 1) ? 4'b0000 : 4'b0001) ||
                {ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== {es, ep, ed, ef}) begin
                errors++;
                $display("FAIL reset_release c=%0d got dig=%b frame=%b seg=%h required dig=%b frame=%b seg=%h",
                         c, ifa.dig, ifa.frame, ifa.seg, ed, ef, es);
            end
        end
        checks++;
        if (ifb.dig !== 4'b0001) begin
            errors++;
            $display("FAIL reset_nodead_dig got %b required 0001", ifb.dig);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== 13'd0 ||
            {ifb.seg, ifb.dp, ifb.dig, ifb.frame} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got a=%h b=%h required 0", {ifa.seg, ifa.dp, ifa.dig, ifa.frame},
                     {ifb.seg, ifb.dp, ifb.dig, ifb.frame});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_scan();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        logic [6:0] slot_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        int frames = 0;
        set_in(5'd4, 5'd3, 5'd2, 5'd1);
        sync_frame();
        for (int c = 0; c < 32; c++) begin
            tick();
            expect_out(1, 1'b1, es, ed, ep, ef);
            frames += int'(ifa.frame);
            checks++;
            if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== {es, ep, ed, ef} ||
                ((c % 4) != 0 && ifa.seg !== slot_seg[(c % 16) / 4])) begin
                errors++;
                $display("FAIL basic_scan c=%0d got seg=%h dp=%b dig=%b frame=%b required seg=%h dp=%b dig=%b frame=%b",
                         c, ifa.seg, ifa.dp, ifa.dig, ifa.frame, es, ep, ed, ef);
            end
        end
        checks++;
        if (frames !== 2) begin
            errors++;
            $display("FAIL basic_frame_count got %0d required 2", frames);
        end
    endtask

    task automatic test_lzb();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        logic [6:0] exp_a [4] = '{7'h07, 7'h6D, 7'h00, 7'h00};
        logic [6:0] exp_z [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) set_in(5'd7, 5'd5, 5'd0, 5'd0);
            else           set_in(5'd0, 5'd0, 5'd0, 5'd0);
            sync_frame();
            for (int c = 0; c < 16; c++) begin
                tick();
                expect_out(1, 1'b1, es, ed, ep, ef);
                checks++;
                if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== {es, ep, ed, ef} ||
                    ((c % 4) != 0 && (ifa.dig !== 4'(1 << (c / 4)) ||
                     ifa.seg !== ((pass == 0) ? exp_a[c / 4] : exp_z[c / 4])))) begin
                    errors++;
                    $display("FAIL lzb pass=%0d c=%0d got seg=%h dig=%b required seg=%h dig=%b",
                             pass, c, ifa.seg, ifa.dig, es, ed);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        set_in(5'd4, 5'd3, 5'd2, 5'd1);
        sync_frame();
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 6) set_in(5'd9, 5'd3, 5'd2, 5'd1);
            expect_out(1, 1'b1, es, ed, ep, ef);
            checks++;
            if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== {es, ep, ed, ef} ||
                (ifa.dig === 4'b0001 && ifa.seg !== ((c <= 16) ? 7'h66 : 7'h6F))) begin
                errors++;
                $display("FAIL tear_free c=%0d got seg=%h dig=%b required seg=%h dig=%b",
                         c, ifa.seg, ifa.dig, es, ed);
            end
        end
    endtask

    task automatic test_dp_hex();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        set_in(5'h10, 5'h00, 5'h1A, 5'h00);
        sync_frame();
        for (int c = 0; c < 16; c++) begin
            tick();
            expect_out(1, 1'b1, es, ed, ep, ef);
            checks++;
            if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== {es, ep, ed, ef} ||
                (ifa.dig === 4'b0000 && ifa.dp !== 1'b0) ||
                (ifa.dig === 4'b0100 && {ifa.seg, ifa.dp} !== {7'h77, 1'b1})) begin
                errors++;
                $display("FAIL dp_hex c=%0d got seg=%h dp=%b dig=%b required seg=%h dp=%b dig=%b",
                         c, ifa.seg, ifa.dp, ifa.dig, es, ep, ed);
            end
        end
    endtask

    task automatic test_nolzb_nodead();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        set_in(5'd0, 5'd0, 5'd0, 5'd0);
        sync_frame();
        for (int c = 0; c < 16; c++) begin
            tick();
            expect_out(0, 1'b0, es, ed, ep, ef);
            checks++;
            if ({ifb.seg, ifb.dp, ifb.dig, ifb.frame} !== {es, ep, ed, ef} ||
                ifb.seg !== 7'h3F || ifb.dig === 4'b0000) begin
                errors++;
                $display("FAIL nolzb c=%0d got seg=%h dig=%b required seg=%h dig=%b",
                         c, ifb.seg, ifb.dig, es, ed);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] es; logic [3:0] ed; logic ep, ef;
        for (int c = 0; c < 96; c++) begin
            if ($urandom_range(3, 0) == 0)
                set_in(5'($urandom), 5'($urandom_range(1, 0) ? 0 : $urandom),
                       5'($urandom_range(1, 0) ? 0 : $urandom), 5'($urandom_range(1, 0) ? 0 : $urandom));
            tick();
            expect_out(1, 1'b1, es, ed, ep, ef);
            checks++;
            if ({ifa.seg, ifa.dp, ifa.dig, ifa.frame} !== {es, ep, ed, ef}) begin
                errors++;
                $display("FAIL random_a k=%0d got seg=%h dp=%b dig=%b frame=%b required seg=%h dp=%b dig=%b frame=%b",
                         k, ifa.seg, ifa.dp, ifa.dig, ifa.frame, es, ep, ed, ef);
            end
            expect_out(0, 1'b0, es, ed, ep, ef);
            checks++;
            if ({ifb.seg, ifb.dp, ifb.dig, ifb.frame} !== {es, ep, ed, ef}) begin
                errors++;
                $display("FAIL random_b k=%0d got seg=%h dp=%b dig=%b frame=%b required seg=%h dp=%b dig=%b frame=%b",
                         k, ifb.seg, ifb.dp, ifb.dig, ifb.frame, es, ep, ed, ef);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        set_in(5'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_basic_scan();
        test_lzb();
        test_tear_free();
        test_dp_hex();
        test_nolzb_nodead();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
